uart_tx_ctrl: RTL

- Buffers byte writes from the memory-access stage's UART store path (uart/uart_we) in a FIFO and serialises them onto a single TX line as 8N1 frames.
- Returns a full/stall indication so the pipeline holds a store instead of losing bytes.
- Sits between memory_ctl's UART outputs and the top-level TXD pin.

---
 rtl/uart_tx_ctrl_pkg.sv | 33 +++
 rtl/uart_tx_ctrl_if.sv | 28 ++
 rtl/uart_tx_ctrl_sync_fifo.sv | 64 ++++++
 rtl/uart_tx_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/uart_tx_ctrl_pkg.sv
// Shared types and constants for the UART transmit path.
`ifndef UART_TX_CTRL_PKG_SV
`define UART_TX_CTRL_PKG_SV

`ifndef UART_ADDR
`define UART_ADDR 32'hFFFF_FF00
`endif

`ifndef UART_DEFAULT_CLKS_PER_BIT
`define UART_DEFAULT_CLKS_PER_BIT 521
`endif

package uart_tx_ctrl_pkg;

  // Transmit FSM states, one per segment of an 8N1 frame.
  typedef enum logic [1:0] {
    UART_TX_IDLE,
    UART_TX_START,
    UART_TX_DATA,
    UART_TX_STOP
  } uart_tx_state_e;

  localparam int unsigned UART_DATA_BITS          = 8;
  localparam int unsigned UART_DEFAULT_FIFO_DEPTH = 16;

  // True for powers of two that are at least 2.
  function automatic logic is_pow2(input int unsigned v);
    return (v >= 2) && ((v & (v - 1)) == 0);
  endfunction

endpackage

`endif

// File: rtl/uart_tx_ctrl_if.sv
// Store-path and status bundle between memory_ctl and the UART transmitter.
interface uart_tx_ctrl_if #(
  parameter int unsigned FIFO_DEPTH = 16
);
  import uart_tx_ctrl_pkg::*;

  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;

  logic [UART_DATA_BITS-1:0] wData;
  logic                      we;
  logic                      full;
  logic                      txd;
  logic                      busy;
  logic [LW-1:0]             level;

  // Requester side: the pipeline's UART store path.
  modport master (
    output wData, we,
    input  full, txd, busy, level
  );

  // Transmitter side.
  modport slave (
    input  wData, we,
    output full, txd, busy, level
  );

endinterface

// File: rtl/uart_tx_ctrl_sync_fifo.sv
// Single-clock FIFO with occupancy count; reusable for a future RX path.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q;
  logic [AW-1:0]    rd_q;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  // Full/empty come from the registered level only, so a pop never frees
  // a slot for a push in the same cycle.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem_q[rd_q];
  assign level   = level_q;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_q] <= din;
    end
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) begin
        wr_q <= wr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_q <= rd_q + AW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmitter: buffers store-path bytes and shifts them out as 8N1.
module uart_tx_ctrl
  import uart_tx_ctrl_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = `UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = UART_DEFAULT_FIFO_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  uart_tx_ctrl_if.slave bus
);

  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam int unsigned LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_cpb
    $error("uart_tx_ctrl: CLKS_PER_BIT must be at least 2");
  end
  if (!is_pow2(FIFO_DEPTH)) begin : g_bad_depth
    $error("uart_tx_ctrl: FIFO_DEPTH must be a power of two >= 2");
  end

  uart_tx_state_e            state_q;
  logic [BW-1:0]             baud_q;
  logic [2:0]                bit_q;
  logic [UART_DATA_BITS-1:0] shift_q;
  logic                      txd_q;

  logic [UART_DATA_BITS-1:0] fifo_dout;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic [LW-1:0]             fifo_level;
  logic                      fifo_pop;
  logic                      bit_end;

  assign fifo_pop = (state_q == UART_TX_IDLE) && !fifo_empty;
  assign bit_end  = (baud_q == BAUD_LAST);

  sync_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.we),
    .pop   (fifo_pop),
    .din   (bus.wData),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Frame sequencer; txd is loaded with the level of the segment being
  // entered so the pin is always a flop output.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UART_TX_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      case (state_q)
        UART_TX_IDLE: begin
          txd_q <= 1'b1;
          if (!fifo_empty) begin
            shift_q <= fifo_dout;
            baud_q  <= '0;
            txd_q   <= 1'b0;
            state_q <= UART_TX_START;
          end
        end
        UART_TX_START: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= '0;
            txd_q   <= shift_q[0];
            state_q <= UART_TX_DATA;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        UART_TX_DATA: begin
          if (bit_end) begin
            baud_q  <= '0;
            bit_q   <= bit_q + 3'd1;
            shift_q <= {1'b0, shift_q[UART_DATA_BITS-1:1]};
            if (bit_q == 3'd7) begin
              txd_q   <= 1'b1;
              state_q <= UART_TX_STOP;
            end else begin
              txd_q <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
        UART_TX_STOP: begin
          if (bit_end) begin
            baud_q  <= '0;
            txd_q   <= 1'b1;
            state_q <= UART_TX_IDLE;
          end else begin
            baud_q <= baud_q + BW'(1);
          end
        end
      endcase
    end
  end

  assign bus.txd   = txd_q;
  assign bus.full  = fifo_full;
  assign bus.level = fifo_level;
  assign bus.busy  = (state_q != UART_TX_IDLE) || !fifo_empty;

endmodule
